// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the decode/issue slice: opcode encodings,
//               instruction field bit positions and datapath width defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_OP_WIDTH = 4;
    localparam int DEF_NREG     = 8;

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] ALU_ADD   = 4'h1;
    localparam logic [3:0] ALU_SUB   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_XOR   = 4'h5;
    localparam logic [3:0] ALU_NOT   = 4'h6;
    localparam logic [3:0] ALU_GT    = 4'h7;
    localparam logic [3:0] ALU_EQ    = 4'h8;
    localparam logic [3:0] OPC_LOADI = 4'h9;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : NREG x WIDTH register file, r0 hardwired to zero.
//               Two combinational read ports that forward a same-cycle write,
//               one synchronous write port, async active-low clear.
// Ports       : clk, rst_n          clock / async active-low reset
//               we_i, waddr_i,       write port
//               wdata_i
//               raddr1_i, rdata1_o   read port 1
//               raddr2_i, rdata2_o   read port 2
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr1_i,
    input  logic [AW-1:0]    raddr2_i,
    output logic [WIDTH-1:0] rdata1_o,
    output logic [WIDTH-1:0] rdata2_o
);

    logic [WIDTH-1:0] mem_q [NREG];

    // r0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = mem_q[raddr2_i];
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue
// Description : Decode/issue stage in front of the ALU. Decodes 16-bit words,
//               reads operands (with writeback bypass), tracks outstanding
//               destinations in a scoreboard and stalls on RAW/WAW hazards.
// Ports       : clk, rst_n                      clock / async active-low reset
//               in_valid, in_instr, in_ready     instruction handshake
//               ex_valid, ex_ready               ID/EX handshake
//               ex_alu_op, ex_op1, ex_op2, ex_rd ID/EX payload
//               wb_valid, wb_rd, wb_data         ALU result writeback
//               err_illegal                      illegal opcode pulse
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue
    import cpu_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int OP_WIDTH = DEF_OP_WIDTH,
    parameter int NREG     = DEF_NREG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [15:0]         in_instr,
    output logic                in_ready,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [OP_WIDTH-1:0] ex_alu_op,
    output logic [WIDTH-1:0]    ex_op1,
    output logic [WIDTH-1:0]    ex_op2,
    output logic [2:0]          ex_rd,
    input  logic                wb_valid,
    input  logic [2:0]          wb_rd,
    input  logic [WIDTH-1:0]    wb_data,
    output logic                err_illegal
);

    // ---------------------------------------------------------------- decode
    logic [3:0] w_opc;
    logic [2:0] w_rd, w_rs1, w_rs2;
    logic [7:0] w_imm;
    logic       w_is_alu, w_is_loadi, w_illegal;
    logic       w_use_rs1, w_use_rs2, w_writes;

    assign w_opc = in_instr[OPC_MSB:OPC_LSB];
    assign w_rd  = in_instr[RD_MSB:RD_LSB];
    assign w_rs1 = in_instr[RS1_MSB:RS1_LSB];
    assign w_rs2 = in_instr[RS2_MSB:RS2_LSB];
    assign w_imm = in_instr[IMM_MSB:IMM_LSB];

    assign w_is_alu   = (w_opc >= ALU_ADD) && (w_opc <= ALU_EQ);
    assign w_is_loadi = (w_opc == OPC_LOADI);
    assign w_illegal  = (w_opc > OPC_LOADI);
    assign w_use_rs1  = w_is_alu;
    assign w_use_rs2  = w_is_alu && (w_opc != ALU_NOT);
    assign w_writes   = w_is_alu || w_is_loadi;

    // ------------------------------------------------------------ scoreboard
    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] w_busy;
    logic            w_hazard;

    // A register whose result is arriving this cycle is already resolved.
    always_comb begin
        w_busy = pend_q;
        if (wb_valid) begin
            w_busy[wb_rd] = 1'b0;
        end
    end

    assign w_hazard = (w_use_rs1 && w_busy[w_rs1]) ||
                      (w_use_rs2 && w_busy[w_rs2]) ||
                      (w_writes  && w_busy[w_rd]);

    logic w_accept, w_issue;

    assign in_ready = (!ex_valid || ex_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;
    assign w_issue  = w_accept && w_writes;

    // Issue is applied after writeback so a same-register set wins.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid) begin
            pend_d[wb_rd] = 1'b0;
        end
        if (w_issue) begin
            pend_d[w_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // --------------------------------------------------------- register file
    logic [WIDTH-1:0] w_rdata1, w_rdata2;

    reg_file #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .AW    (3)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (wb_valid),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data),
        .raddr1_i (w_rs1),
        .raddr2_i (w_rs2),
        .rdata1_o (w_rdata1),
        .rdata2_o (w_rdata2)
    );

    // ------------------------------------------------------------ ID/EX reg
    logic                ex_valid_q, ex_valid_d;
    logic [OP_WIDTH-1:0] ex_alu_op_q, ex_alu_op_d;
    logic [WIDTH-1:0]    ex_op1_q, ex_op1_d;
    logic [WIDTH-1:0]    ex_op2_q, ex_op2_d;
    logic [2:0]          ex_rd_q, ex_rd_d;
    logic                err_q, err_d;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_alu_op_d = ex_alu_op_q;
        ex_op1_d    = ex_op1_q;
        ex_op2_d    = ex_op2_q;
        ex_rd_d     = ex_rd_q;
        if (w_issue) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = w_rd;
            if (w_is_loadi) begin
                ex_alu_op_d = OP_WIDTH'(ALU_ADD);
                ex_op1_d    = WIDTH'(w_imm);
                ex_op2_d    = '0;
            end else begin
                ex_alu_op_d = OP_WIDTH'(w_opc);
                ex_op1_d    = w_rdata1;
                ex_op2_d    = w_rdata2;
            end
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
        err_d = w_accept && w_illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_alu_op_q <= '0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            ex_rd_q     <= '0;
            err_q       <= 1'b0;
            pend_q      <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_alu_op_q <= ex_alu_op_d;
            ex_op1_q    <= ex_op1_d;
            ex_op2_q    <= ex_op2_d;
            ex_rd_q     <= ex_rd_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_alu_op   = ex_alu_op_q;
    assign ex_op1      = ex_op1_q;
    assign ex_op2      = ex_op2_q;
    assign ex_rd       = ex_rd_q;
    assign err_illegal = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue
// Description : Self-checking bench for decode_issue: a vector table for the
//               issue/hazard/bypass behaviour plus hand sequences for the
//               ID/EX back-pressure and mid-stall reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_alu_op;
    logic [7:0]  ex_op1, ex_op2;
    logic [2:0]  ex_rd;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        err_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_issue #(
        .WIDTH    (8),
        .OP_WIDTH (4),
        .NREG     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_alu_op   (ex_alu_op),
        .ex_op1      (ex_op1),
        .ex_op2      (ex_op2),
        .ex_rd       (ex_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err_illegal (err_illegal)
    );

    typedef struct packed {
        logic [15:0] instr;
        logic        wbv;
        logic [2:0]  wbrd;
        logic [7:0]  wbd;
        logic        exp_rdy;
        logic        exp_v;
        logic [3:0]  exp_op;
        logic [7:0]  exp_o1;
        logic [7:0]  exp_o2;
        logic [2:0]  exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ex(input string tag, input logic [3:0] op, input logic [7:0] o1,
                          input logic [7:0] o2, input logic [2:0] rd);
        chk({tag, ".ex_valid"}, 16'(ex_valid), 16'h1);
        chk({tag, ".alu_op"}, 16'(ex_alu_op), 16'(op));
        chk({tag, ".op1"}, 16'(ex_op1), 16'(o1));
        chk({tag, ".op2"}, 16'(ex_op2), 16'(o2));
        chk({tag, ".rd"}, 16'(ex_rd), 16'(rd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           instr     wbv wbrd wbd    rdy v  op     o1     o2     rd  err
        vecs[0]  = '{16'h922A, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 4'h1, 8'h2A, 8'h00, 3'd1, 1'b0}; // LOADI r1,2A
        vecs[1]  = '{16'h1650, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0}; // ADD r3,r1,r2 stall
        vecs[2]  = '{16'h1650, 1'b1, 3'd1, 8'h2A, 1'b1, 1'b1, 4'h1, 8'h2A, 8'h00, 3'd3, 1'b0}; // retry + bypass
        vecs[3]  = '{16'h9405, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 4'h1, 8'h05, 8'h00, 3'd2, 1'b0}; // LOADI r2,05
        vecs[4]  = '{16'h2850, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0}; // SUB r4,r1,r2 stall
        vecs[5]  = '{16'h2850, 1'b1, 3'd2, 8'h05, 1'b1, 1'b1, 4'h2, 8'h2A, 8'h05, 3'd4, 1'b0}; // rs2 bypass
        vecs[6]  = '{16'h6A58, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 4'h6, 8'h2A, 8'h00, 3'd5, 1'b0}; // NOT ignores pending rs2
        vecs[7]  = '{16'h0000, 1'b1, 3'd3, 8'h77, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0}; // NOP + wb r3
        vecs[8]  = '{16'hF000, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b1}; // illegal
        vecs[9]  = '{16'h90FF, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 4'h1, 8'hFF, 8'h00, 3'd0, 1'b0}; // LOADI r0,FF
        vecs[10] = '{16'h2400, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 4'h2, 8'h00, 8'h00, 3'd2, 1'b0}; // SUB r2,r0,r0
        vecs[11] = '{16'h1CD8, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 4'h1, 8'h77, 8'h77, 3'd6, 1'b0}; // ADD r6,r3,r3
        vecs[12] = '{16'h9411, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0}; // WAW on r2
        vecs[13] = '{16'h5F28, 1'b1, 3'd4, 8'h33, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0}; // r5 still pending
        vecs[14] = '{16'h8F18, 1'b1, 3'd5, 8'h44, 1'b1, 1'b1, 4'h8, 8'h33, 8'h77, 3'd7, 1'b0}; // EQ r7,r4,r3

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        ex_ready = 1'b1;
        wb_valid = 1'b0;
        wb_rd    = 3'd0;
        wb_data  = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        chk("rst.ex_valid", 16'(ex_valid), 16'h0);
        chk("rst.alu_op", 16'(ex_alu_op), 16'h0);
        chk("rst.op1", 16'(ex_op1), 16'h0);
        chk("rst.op2", 16'(ex_op2), 16'h0);
        chk("rst.rd", 16'(ex_rd), 16'h0);
        chk("rst.err", 16'(err_illegal), 16'h0);
        chk("rst.in_ready", 16'(in_ready), 16'h1);

        // ------------------------------------------------------- vector table
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            wb_valid = vecs[i].wbv;
            wb_rd    = vecs[i].wbrd;
            wb_data  = vecs[i].wbd;
            #1;
            chk($sformatf("v%0d.in_ready", i), 16'(in_ready), 16'(vecs[i].exp_rdy));
            tick();
            wb_valid = 1'b0;
            in_valid = 1'b0;
            chk($sformatf("v%0d.ex_valid", i), 16'(ex_valid), 16'(vecs[i].exp_v));
            chk($sformatf("v%0d.err", i), 16'(err_illegal), 16'(vecs[i].exp_err));
            if (vecs[i].exp_v) begin
                chk($sformatf("v%0d.alu_op", i), 16'(ex_alu_op), 16'(vecs[i].exp_op));
                chk($sformatf("v%0d.op1", i), 16'(ex_op1), 16'(vecs[i].exp_o1));
                chk($sformatf("v%0d.op2", i), 16'(ex_op2), 16'(vecs[i].exp_o2));
                chk($sformatf("v%0d.rd", i), 16'(ex_rd), 16'(vecs[i].exp_rd));
            end
        end

        // ------------------------------------ ID/EX back-pressure for 3 cycles
        in_valid = 1'b1;
        in_instr = 16'h9210;            // LOADI r1,10
        ex_ready = 1'b1;
        tick();
        chk_ex("bp.first", 4'h1, 8'h10, 8'h00, 3'd1);
        ex_ready = 1'b0;
        in_instr = 16'h9620;            // LOADI r3,20
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp.c%0d.in_ready", c), 16'(in_ready), 16'h0);
            tick();
            chk_ex($sformatf("bp.c%0d", c), 4'h1, 8'h10, 8'h00, 3'd1);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", 16'(in_ready), 16'h1);
        tick();
        chk_ex("bp.queued", 4'h1, 8'h20, 8'h00, 3'd3);
        in_valid = 1'b0;
        tick();
        chk("bp.drain.ex_valid", 16'(ex_valid), 16'h0);

        // ---------------------------------------------- reset while stalled
        in_valid = 1'b1;
        in_instr = 16'h9801;            // LOADI r4,01
        ex_ready = 1'b0;
        tick();
        chk_ex("rs.pre", 4'h1, 8'h01, 8'h00, 3'd4);
        in_instr = 16'h1650;            // ADD r3,r1,r2 (r1 and r3 pending)
        #1;
        chk("rs.pre.in_ready", 16'(in_ready), 16'h0);
        rst_n = 1'b0;
        #1;
        chk("rs.ex_valid", 16'(ex_valid), 16'h0);
        chk("rs.alu_op", 16'(ex_alu_op), 16'h0);
        chk("rs.op1", 16'(ex_op1), 16'h0);
        chk("rs.op2", 16'(ex_op2), 16'h0);
        chk("rs.rd", 16'(ex_rd), 16'h0);
        chk("rs.err", 16'(err_illegal), 16'h0);
        in_valid = 1'b0;
        tick();
        rst_n    = 1'b1;
        ex_ready = 1'b1;
        #1;
        chk("rs.post.in_ready", 16'(in_ready), 16'h1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_ex("rs.post", 4'h1, 8'h00, 8'h00, 3'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_issue.md
# decode_issue

Decode/issue stage directly upstream of the ALU. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal register file. It registers `{alu_op, op1, op2, rd}` into an ID/EX output register that feeds the ALU, and takes ALU results back as writebacks. A per-register scoreboard stalls issue on RAW/WAW hazards, with same-cycle writeback bypass.

## Interface
- `WIDTH`, 8: datapath / register width.
- `OP_WIDTH`, 4: ALU opcode width.
- `NREG`, 8: architectural registers; r0 reads zero.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  instruction available.
- `in_instr`  in  16  instruction word.
- `in_ready`  out  1  instruction accepted this cycle when high with `in_valid`.
- `ex_valid`  out  1  ID/EX register holds an issued op.
- `ex_ready`  in  1  ALU side consumes ID/EX this cycle.
- `ex_alu_op`  out  OP_WIDTH  ALU opcode.
- `ex_op1`, `ex_op2`  out  WIDTH  operands.
- `ex_rd`  out  3  destination register.
- `wb_valid`  in  1  writeback strobe.
- `wb_rd`  in  3  writeback register.
- `wb_data`  in  WIDTH  writeback value.
- `err_illegal`  out  1  one-cycle pulse: illegal opcode consumed.

## Operation
- Format: `[15:12]` opc, `[11:9]` rd, `[8:6]` rs1, `[5:3]` rs2, `[7:0]` imm (LOADI only).
- opc 0001–1000: ALU ops (add, sub, or, and, xor, not, gt, eq) issued unchanged as `ex_alu_op`; op1=R[rs1], op2=R[rs2]. For 0110 (not), rs2 is unused and never causes a stall.
- opc 1001 LOADI: issued as alu_op 0001, op1=imm, op2=0; no source reads.
- opc 0000 NOP: consumed, nothing issued.
- opc 1010–1111: consumed, nothing issued, `err_illegal` pulses the following cycle.
- Scoreboard: one pending bit per register. Issue sets `pend[rd]`. `wb_valid` clears `pend[wb_rd]` and writes `R[wb_rd]`. Set and clear of the same register in the same cycle: set wins.
- r0: reads 0, writes ignored, never pending. An instruction with rd=0 still issues.
- Hazard: stall if any used source or rd is pending. Exception: a pending register being written back this cycle is not a hazard.
- Bypass: a source register matching `wb_rd` while `wb_valid` takes `wb_data`.
- `in_ready = (!ex_valid | ex_ready) & !hazard`. NOP and illegal words are gated the same way.
- ID/EX holds its contents while `ex_valid & !ex_ready`.

## Timing
- Accept in cycle N → `ex_valid` and fields valid from N+1. Sustained issue rate is one per cycle.
- `ex_valid` falls the cycle after `ex_ready` when nothing new is accepted.
- `in_ready` is combinational from `in_instr`, `ex_*`, `wb_*` and the scoreboard. It does not depend on `in_valid`.
- Writeback in cycle N is visible to an instruction accepted in N via bypass, and to later instructions via the register file.
- Reset (any time, including mid-stall): `ex_valid`=0, `ex_alu_op`/`ex_op1`/`ex_op2`/`ex_rd`=0, `err_illegal`=0, all registers 0, scoreboard clear. With `ex_valid`=0 and no pending registers, `in_ready` is 1 right after reset deassertion.
- A writeback to a non-pending register is legal: it updates R and the scoreboard stays clear.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams (ALU_ADD…ALU_EQ, OPC_NOP, OPC_LOADI);
  - instruction field bit positions;
  - `WIDTH`/`OP_WIDTH` defaults.
- Sub-module `reg_file`:
  - NREG×WIDTH storage;
  - two combinational read ports with write-bypass;
  - one synchronous write port;
  - r0 hardwired to zero;
  - async active-low reset clears contents.
- Decode, scoreboard and the ID/EX register stay in `decode_issue`.

## Test plan
- Reset, then LOADI r1,0x2A with `ex_ready`=1 → next cycle `ex_valid`=1, alu_op 0001, op1 0x2A, op2 0, rd 1; `pend[1]`=1.
- ADD r3,r1,r2 while r1 pending, no writeback → `in_ready`=0 held. Then `wb_valid` rd 1 data 0x2A in the same cycle as the retry → accepted, op1=0x2A via bypass.
- `ex_ready`=0 for 3 cycles with valid ID/EX → `in_ready`=0 and all `ex_*` outputs stable. Raise `ex_ready` → queued instruction issues the next cycle.
- Instruction 0xF000 → consumed, no `ex_valid`, `err_illegal` high for exactly one cycle. NOP 0x0000 → consumed silently.
- Back-to-back LOADI r0,0xFF then SUB r2,r0,r0 → no stall, op1=op2=0.
- Assert `rst_n`=0 while stalled with `ex_valid`=1 and scoreboard bits set → all outputs 0, scoreboard clear, `in_ready`=1 after release.
